// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32I front end.
//   XLEN              datapath / PC width
//   IMEM_AW           instruction-memory word-address width
//   INSTR_W           instruction word width
//   NOP_INSTR         canonical NOP (addi x0, x0, 0)
//   RESET_PC_DEFAULT  first PC fetched after reset
//   ifid_src_e        which source feeds the IF/ID register on an advancing edge
package riscv_pkg;

   localparam int XLEN    = 32;
   localparam int IMEM_AW = 8;
   localparam int INSTR_W = 32;

   localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0]        RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      SRC_BUBBLE = 2'd0,
      SRC_RESP   = 2'd1,
      SRC_SKID   = 2'd2
   } ifid_src_e;

endpackage

// File: rtl/riscv_fetch_if.sv
// riscv_fetch_if: request/response bus between the fetch stage and the
// synchronous instruction memory (one-cycle read latency).
//   en     read enable, sampled by the memory on the rising edge
//   addr   word address
//   rdata  data for the address sampled on the previous enabled edge
// Modports: master = fetch stage, slave = memory.
interface riscv_fetch_if #(
   parameter int AW = 8
);
   logic          en;
   logic [AW-1:0] addr;
   logic [31:0]   rdata;

   modport master (output en, output addr, input rdata);
   modport slave  (input en, input addr, output rdata);
endinterface

// File: rtl/riscv_fetch_skid.sv
// riscv_fetch_skid: one-entry holding register for a memory response that
// arrived while decode was stalled.
//   clk, rst          clock and synchronous active-high reset
//   load              park (load_pc, load_instr); ignored when clear is high
//   clear             drop the parked entry
//   valid, pc, instr  parked entry
module riscv_fetch_skid
   import riscv_pkg::*;
#(
   parameter int XLEN = riscv_pkg::XLEN
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               clear,
   input  logic [XLEN-1:0]    load_pc,
   input  logic [INSTR_W-1:0] load_instr,
   output logic               valid,
   output logic [XLEN-1:0]    pc,
   output logic [INSTR_W-1:0] instr
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= NOP_INSTR;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= load_pc;
         instr <= load_instr;
      end
   end

endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction-fetch stage of the pipelined RV32I core.
// Keeps the fetch PC, issues one read per cycle to the instruction memory,
// tracks the single outstanding response, parks it in a skid register when
// decode stalls, and squashes wrong-path work on a redirect.
//   clk, rst        clock, synchronous active-high reset
//   stall           decode cannot accept; IF/ID holds
//   redirect_valid  taken branch/jump from EX; overrides stall
//   redirect_pc     redirect target (low two bits ignored)
//   imem            instruction-memory bus (master side)
//   ifid_*          registered IF/ID bundle; instr is NOP when not valid
//   fetch_count     instructions latched into IF/ID as valid (wraps)
module riscv_fetch
   import riscv_pkg::*;
#(
   parameter int              XLEN     = riscv_pkg::XLEN,
   parameter int              IMEM_AW  = riscv_pkg::IMEM_AW,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stall,
   input  logic                redirect_valid,
   input  logic [XLEN-1:0]     redirect_pc,
   riscv_fetch_if.master       imem,
   output logic                ifid_valid,
   output logic [XLEN-1:0]     ifid_pc,
   output logic [XLEN-1:0]     ifid_pc4,
   output logic [INSTR_W-1:0]  ifid_instr,
   output logic [31:0]         fetch_count
);

   logic [XLEN-1:0]    fetch_pc_reg;
   logic [XLEN-1:0]    resp_pc_reg;
   logic               resp_valid_reg;

   logic               skid_valid;
   logic [XLEN-1:0]    skid_pc;
   logic [INSTR_W-1:0] skid_instr;
   logic               skid_load;
   logic               skid_clear;

   ifid_src_e          src_sel;
   logic [XLEN-1:0]    src_pc;
   logic [INSTR_W-1:0] src_instr;

   // A read is only issued on edges where the PC actually advances.
   assign imem.en   = ~rst & ~stall & ~redirect_valid;
   assign imem.addr = fetch_pc_reg[IMEM_AW+1:2];

   // The outstanding response is parked only when decode stalls; the
   // one-outstanding-read rule means the skid is always empty at that point.
   assign skid_load  = stall & ~redirect_valid & resp_valid_reg & ~skid_valid;
   // Any advancing edge drains the skid into IF/ID; a redirect discards it.
   assign skid_clear = redirect_valid | ~stall;

   riscv_fetch_skid #(
      .XLEN(XLEN)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (skid_load),
      .clear      (skid_clear),
      .load_pc    (resp_pc_reg),
      .load_instr (imem.rdata),
      .valid      (skid_valid),
      .pc         (skid_pc),
      .instr      (skid_instr)
   );

   // The skid is always older than the live response, so it wins.
   always_comb begin
      src_sel   = SRC_BUBBLE;
      src_pc    = ifid_pc;
      src_instr = NOP_INSTR;
      if (skid_valid) begin
         src_sel   = SRC_SKID;
         src_pc    = skid_pc;
         src_instr = skid_instr;
      end else if (resp_valid_reg) begin
         src_sel   = SRC_RESP;
         src_pc    = resp_pc_reg;
         src_instr = imem.rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_reg   <= RESET_PC;
         resp_pc_reg    <= '0;
         resp_valid_reg <= 1'b0;
         ifid_valid     <= 1'b0;
         ifid_pc        <= '0;
         ifid_pc4       <= XLEN'(4);
         ifid_instr     <= NOP_INSTR;
         fetch_count    <= '0;
      end else if (redirect_valid) begin
         // Drop the in-flight read and the IF/ID entry; ifid_pc is kept.
         fetch_pc_reg   <= redirect_pc & ~XLEN'(3);
         resp_valid_reg <= 1'b0;
         ifid_valid     <= 1'b0;
         ifid_instr     <= NOP_INSTR;
      end else if (stall) begin
         resp_valid_reg <= 1'b0;
      end else begin
         resp_pc_reg    <= fetch_pc_reg;
         resp_valid_reg <= 1'b1;
         fetch_pc_reg   <= fetch_pc_reg + XLEN'(4);
         if (src_sel == SRC_BUBBLE) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
         end else begin
            ifid_valid  <= 1'b1;
            ifid_pc     <= src_pc;
            ifid_pc4    <= src_pc + XLEN'(4);
            ifid_instr  <= src_instr;
            fetch_count <= fetch_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: directed, table-driven bench for riscv_fetch with a
// behavioural one-cycle-latency instruction memory. Memory word n holds
// {16'h0, n[7:0], 8'h93}.
module tb_riscv_fetch;
   import riscv_pkg::*;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_pc4;
   logic [31:0] ifid_instr;
   logic [31:0] fetch_count;

   riscv_fetch_if #(.AW(8)) bus ();

   riscv_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (bus),
      .ifid_valid     (ifid_valid),
      .ifid_pc        (ifid_pc),
      .ifid_pc4       (ifid_pc4),
      .ifid_instr     (ifid_instr),
      .fetch_count    (fetch_count)
   );

   logic [31:0] mem [256];

   always_ff @(posedge clk) begin
      if (bus.en) bus.rdata <= mem[bus.addr];
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] ins(input logic [31:0] pc);
      logic [7:0] w;
      w = pc[9:2];
      return {16'h0, w, 8'h93};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        stall;
      logic        redir;
      logic [31:0] rpc;
      logic        exp_en;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
      logic [31:0] exp_count;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic s, input logic d, input logic [31:0] rp,
                               input logic en, input logic v, input logic [31:0] pc, input int cnt);
      vec_t t;
      t.rst = r; t.stall = s; t.redir = d; t.rpc = rp;
      t.exp_en = en; t.exp_valid = v; t.exp_pc = pc;
      t.exp_instr = v ? ins(pc) : NOP_INSTR;
      t.exp_count = cnt;
      return t;
   endfunction

   // Drive inputs away from the active edge, then let combinational outputs settle.
   task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] rp);
      @(negedge clk);
      rst = r; stall = s; redirect_valid = d; redirect_pc = rp;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc, input int cnt);
      chk({tag, "_valid"}, {31'b0, ifid_valid}, {31'b0, v});
      chk({tag, "_pc"},    ifid_pc, pc);
      chk({tag, "_pc4"},   ifid_pc4, pc + 32'd4);
      chk({tag, "_instr"}, ifid_instr, v ? ins(pc) : NOP_INSTR);
      chk({tag, "_count"}, fetch_count, cnt);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = {16'h0, 8'(i), 8'h93};
      rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

      //               rst  stl  red  rpc        en   v    pc         cnt
      // Reset release and free run: 8 deliveries.
      vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,   0));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h0,   0));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   1));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h4,   2));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h8,   3));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'hC,   4));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h10,  5));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h14,  6));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h18,  7));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h1C,  8));
      // Restart; stall 3 cycles with 0x8 in IF/ID and 0xC in flight.
      vecs.push_back(mk(1, 0, 0, 32'h0,   0, 0, 32'h0,   0));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h0,   0));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   1));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h4,   2));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h8,   3));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 32'h8,   3));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 32'h8,   3));
      vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 32'h8,   3));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'hC,   4));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h10,  5));
      // Redirect to 0x40 with 0x10 in IF/ID.
      vecs.push_back(mk(0, 0, 1, 32'h40,  0, 0, 32'h10,  5));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h10,  5));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h40,  6));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h44,  7));
      // Redirect together with stall, misaligned target.
      vecs.push_back(mk(0, 1, 1, 32'h23,  0, 0, 32'h44,  7));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h44,  7));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h20,  8));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h24,  9));
      // Fill the skid with 0x28, then reset during the stall.
      vecs.push_back(mk(0, 1, 0, 32'h0,   0, 1, 32'h24,  9));
      vecs.push_back(mk(1, 1, 0, 32'h0,   0, 0, 32'h0,   0));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 0, 32'h0,   0));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h0,   1));
      vecs.push_back(mk(0, 0, 0, 32'h0,   1, 1, 32'h4,   2));

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("v%0d", i);
         drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
         chk({tag, "_en"}, {31'b0, bus.en}, {31'b0, vecs[i].exp_en});
         tick();
         chk({tag, "_valid"}, {31'b0, ifid_valid}, {31'b0, vecs[i].exp_valid});
         chk({tag, "_pc"},    ifid_pc, vecs[i].exp_pc);
         chk({tag, "_pc4"},   ifid_pc4, vecs[i].exp_pc + 32'd4);
         chk({tag, "_instr"}, ifid_instr, vecs[i].exp_instr);
         chk({tag, "_count"}, fetch_count, vecs[i].exp_count);
         $display("vec %0d: rst=%0b stall=%0b redir=%0b -> valid=%0b pc=%h instr=%h count=%0d",
                  i, vecs[i].rst, vecs[i].stall, vecs[i].redir, ifid_valid, ifid_pc, ifid_instr, fetch_count);
      end

      // Address wrap: redirect near the top of the 1 KiB memory window.
      drive(0, 0, 1, 32'h3F8);
      tick();
      chk_ifid("wrap_redir", 0, 32'h4, 2);
      drive(0, 0, 0, 32'h0);
      chk("wrap_addr_3f8", {24'b0, bus.addr}, 32'hFE);
      tick();
      chk_ifid("wrap_bubble", 0, 32'h4, 2);
      drive(0, 0, 0, 32'h0);
      chk("wrap_addr_3fc", {24'b0, bus.addr}, 32'hFF);
      tick();
      chk_ifid("wrap_3f8", 1, 32'h3F8, 3);
      drive(0, 0, 0, 32'h0);
      chk("wrap_addr_400", {24'b0, bus.addr}, 32'h00);
      tick();
      chk_ifid("wrap_3fc", 1, 32'h3FC, 4);
      drive(0, 0, 0, 32'h0);
      tick();
      chk_ifid("wrap_400", 1, 32'h400, 5);
      chk("wrap_noX", {31'b0, $isunknown({ifid_valid, ifid_pc, ifid_pc4, ifid_instr, fetch_count, bus.addr, bus.en})}, 32'h0);
      drive(0, 0, 0, 32'h0);
      tick();
      chk_ifid("wrap_404", 1, 32'h404, 6);
      $display("wrap: pc=%h instr=%h count=%0d", ifid_pc, ifid_instr, fetch_count);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_fetch.md
Name: riscv_fetch

Overview:
- Instruction-fetch (IF) stage of the pipelined RV32I core.
- Sits directly upstream of the decode stage and drives the synchronous instruction memory (`insmem`, one-cycle read latency).
- Holds the PC and issues one read per cycle.
- Absorbs downstream stalls with a one-entry skid buffer and squashes wrong-path fetches on branch/jump redirect.
- Presents a registered IF/ID bundle (valid, pc, pc+4, instr).

Parameters:
- XLEN, 32, datapath and PC width.
- IMEM_AW, 8, instruction-memory word-address width (256 words).
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- stall  input  1  decode cannot accept; hold IF/ID outputs.
- redirect_valid  input  1  EX-resolved taken branch/jump; squash and refetch.
- redirect_pc  input  XLEN  redirect target; bits [1:0] ignored (forced 0).
- imem_en  output  1  read enable to `insmem`; combinational `~rst & ~stall & ~redirect_valid`.
- imem_addr  output  IMEM_AW  word address, `fetch_pc[IMEM_AW+1:2]`.
- imem_rdata  input  32  read data for the address sampled on the previous edge.
- ifid_valid  output  1  IF/ID holds a real instruction.
- ifid_pc  output  XLEN  PC of ifid_instr.
- ifid_pc4  output  XLEN  ifid_pc + 4.
- ifid_instr  output  32  instruction word; NOP (32'h00000013) when invalid.
- fetch_count  output  32  count of instructions delivered to decode (wraps).

Behaviour:
- Reset (rst=1 at edge):
  - fetch_pc=RESET_PC, resp_valid=0, skid_valid=0.
  - ifid_valid=0, ifid_pc=0, ifid_pc4=4, ifid_instr=NOP, fetch_count=0.
  - Reset mid-operation discards any in-flight read and the skid contents.
- Internal state:
  - fetch_pc: next address to issue.
  - resp_pc/resp_valid: address issued last cycle; imem_rdata is meaningful this cycle iff resp_valid.
  - skid_valid/skid_pc/skid_instr: one parked response.
- Edge priority: rst > redirect_valid > stall > normal.
- Normal (no stall, no redirect):
  - Issue: resp_pc<=fetch_pc, resp_valid<=1, fetch_pc<=fetch_pc+4 (mod 2^XLEN).
  - IF/ID source order: skid if skid_valid; else imem_rdata if resp_valid; else bubble (valid=0, instr=NOP, pc held).
  - skid_valid<=0.
  - fetch_count increments whenever the latched ifid_valid=1.
- Stall (no redirect):
  - IF/ID and fetch_pc hold; imem_en=0; resp_valid<=0.
  - If resp_valid and !skid_valid: skid<=(resp_pc, imem_rdata), skid_valid<=1.
  - At most one response is outstanding, so the skid never overflows. A resp_valid with skid already full cannot occur.
- Redirect (any stall state):
  - fetch_pc<=redirect_pc & ~3; resp_valid<=0; skid_valid<=0; ifid_valid<=0, ifid_instr<=NOP; imem_en=0 this cycle.
  - Redirect overrides a simultaneous stall.
- Latency:
  - First valid IF/ID (pc=RESET_PC) is visible after the 2nd rising edge following rst deassertion.
  - After a redirect sampled at edge E: ifid_valid=0 after E and E+1; the target is valid after E+2.
  - Steady-state throughput is 1 instruction/cycle; no bubbles on stall release.
- Ordering: instructions reach decode in strict PC order, with no duplicates or drops across any stall pattern.
- Wrap: fetch_pc wraps at 2^XLEN. imem_addr takes its low bits, so the memory wraps at 4*2^IMEM_AW bytes.

Decomposition:
- Shared package `riscv_pkg`: XLEN, NOP_INSTR=32'h00000013, RESET_PC default, IF/ID bundle field widths.
- Sub-module `riscv_fetch_skid`: one-entry pc+instr skid register with load/clear/valid. Top level keeps the PC, response tracking, output mux and counter.

Test Plan:
- Reset release, memory word n = 32'h0000_0n93 for n = 0..7, no stall → ifid_pc 0,4,8,… on consecutive cycles starting 2 edges after reset; instr matches; fetch_count=8 after 8 deliveries.
- Stall for 3 cycles while instr@0x8 is in decode and 0xC is in flight → IF/ID holds 0x8; imem_en=0; on release 0xC then 0x10 arrive back-to-back, with no duplicate or skip.
- Redirect to 0x40 while instr@0x10 is in IF/ID → ifid_valid=0 for 2 cycles, then pc 0x40, 0x44; 0x14/0x18 never appear valid.
- Redirect and stall asserted together, redirect_pc=0x23 → redirect wins; first valid pc=0x20; skid cleared.
- Assert rst for 1 cycle during a stall with skid full → all outputs return to reset values; refetch starts at RESET_PC.
- Run to fetch_pc=0x3FC with IMEM_AW=8 → next imem_addr=0; ifid_pc=0x400; no X on outputs.
